// File: rtl/mac_column_sequencer.sv
// Bit-serial MAC column sequencer.
// Accepts a tile of signed weights and walks its bit columns MSB first. For
// each column and each group of eight weights it chooses the cheaper way to
// form the group sum (add the ones, or subtract the zeros from the group
// total) and packs the chosen positions into four mux slots.
module mac_column_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int VEC_LENGTH = 16
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             w_valid,
   output logic                             w_ready,
   input  logic [DATA_WIDTH*VEC_LENGTH-1:0] w_data,
   input  logic                             w_first,
   output logic                             col_valid,
   input  logic                             col_ready,
   output logic [4*(VEC_LENGTH/2)-1:0]      act_sel,
   output logic [VEC_LENGTH/8-1:0]          is_skip_zero,
   output logic [2:0]                       column_idx,
   output logic                             is_msb,
   output logic                             load_accum,
   output logic                             tile_done
);

   localparam int GROUPS = VEC_LENGTH / 8;
   localparam int SLOTS = 4 * GROUPS;
   localparam logic [2:0] MSB_COL = 3'(DATA_WIDTH - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                            state;
   logic [DATA_WIDTH*VEC_LENGTH-1:0]  weights_q;
   logic                              accept;
   logic                              advance;
   logic [DATA_WIDTH*VEC_LENGTH-1:0]  src_w;
   logic [2:0]                        next_col;
   logic [GROUPS-1:0]                 next_skip;
   logic [4*SLOTS-1:0]                next_act;

   // A new tile is only taken while idle or exactly when column 0 leaves,
   // which lets back-to-back tiles stream without a bubble.
   assign advance = col_valid & col_ready;
   assign w_ready = ~reset & ((state == IDLE) | (advance & (column_idx == 3'd0)));
   assign accept  = w_valid & w_ready;

   // The next command comes either from the incoming tile (its MSB column)
   // or from the latched tile (the column below the current one).
   assign src_w    = accept ? w_data : weights_q;
   assign next_col = accept ? MSB_COL : column_idx - 3'd1;

   // Per group: count ones in the next column, pick the sparser polarity and
   // pack the matching local positions into slots; empty slots select 8.
   always_comb begin
      int n1;
      int fill;
      next_skip = '0;
      next_act  = {SLOTS{4'd8}};
      for (int g = 0; g < GROUPS; g++) begin
         n1 = 0;
         for (int p = 0; p < 8; p++) begin
            if (src_w[(8*g+p)*DATA_WIDTH + int'(next_col)])
               n1 = n1 + 1;
         end
         next_skip[g] = (n1 <= 4);
         fill = 0;
         for (int p = 0; p < 8; p++) begin
            if ((src_w[(8*g+p)*DATA_WIDTH + int'(next_col)] == next_skip[g]) && (fill < 4)) begin
               next_act[(4*g+fill)*4 +: 4] = 4'(p);
               fill = fill + 1;
            end
         end
      end
   end

   // Control FSM; every command field is registered so col_ready never
   // reaches them combinationally.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         col_valid    <= 1'b0;
         column_idx   <= 3'd0;
         is_msb       <= 1'b0;
         load_accum   <= 1'b0;
         tile_done    <= 1'b0;
         is_skip_zero <= '0;
         act_sel      <= {SLOTS{4'd8}};
         weights_q    <= '0;
      end else if (accept) begin
         state        <= RUN;
         weights_q    <= w_data;
         col_valid    <= 1'b1;
         column_idx   <= next_col;
         is_msb       <= (next_col == MSB_COL);
         load_accum   <= w_first;
         tile_done    <= (next_col == 3'd0);
         is_skip_zero <= next_skip;
         act_sel      <= next_act;
      end else if (advance) begin
         if (column_idx == 3'd0) begin
            state      <= IDLE;
            col_valid  <= 1'b0;
            load_accum <= 1'b0;
            tile_done  <= 1'b0;
         end else begin
            column_idx   <= next_col;
            is_msb       <= (next_col == MSB_COL);
            load_accum   <= 1'b0;
            tile_done    <= (next_col == 3'd0);
            is_skip_zero <= next_skip;
            act_sel      <= next_act;
         end
      end
   end

endmodule

// File: doc/mac_column_sequencer.md
MAC_COLUMN_SEQUENCER -- requirements
Module: mac_column_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the weight bit width and the number of bit-columns per tile.
REQ-002 The block SHALL have parameter VEC_LENGTH, default 16, meaning weights per tile; groups of 8 give VEC_LENGTH/8 groups.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- w_valid  in  1  weight tile offered.
- w_ready  out  1  tile accepted when w_valid&w_ready.
- w_data  in  DATA_WIDTH x VEC_LENGTH  signed weights, element k = weight k.
- w_first  in  1  tile starts a new accumulation from result_prev.
- col_valid  out  1  column command valid.
- col_ready  in  1  downstream MAC consumes command.
- act_sel  out  4 x VEC_LENGTH/2  mux selects, slot s of group g = act_sel[4g+s].
- is_skip_zero  out  1 x VEC_LENGTH/8  per group: 1 = sum selected ones, 0 = subtract zeros from group sum.
- column_idx  out  3  bit position of current column.
- is_msb  out  1  column is the sign bit.
- load_accum  out  1  MAC loads result_prev this column.
- tile_done  out  1  current command is the last column of the tile.
REQ-004 One clock; reset is synchronous and active-high.

Function
REQ-005 States SHALL be IDLE and RUN.
REQ-006 w_ready SHALL be 1 in IDLE, and 1 in RUN only when col_valid&col_ready&column_idx==0; otherwise 0.
REQ-007 On tile acceptance, the block SHALL latch w_data and w_first, enter RUN, and present column 7 with col_valid=1 on the next cycle (latency 1).
REQ-008 Columns SHALL be issued MSB first: 7,6,...,0, advancing one column per col_valid&col_ready cycle; the command SHALL hold stable while col_ready=0.
REQ-009 is_msb SHALL be 1 only for column_idx==DATA_WIDTH-1.
REQ-010 load_accum SHALL equal the latched w_first on column 7 and be 0 on all other columns.
REQ-011 tile_done SHALL be 1 only on column 0.
REQ-012 Group ones count: for each group g, n1 = number of 1s in bit column_idx of weights 8g..8g+7; is_skip_zero[g] SHALL be 1 if n1<=4, else 0.
REQ-013 Selected positions: if is_skip_zero[g]=1, the selected positions SHALL be the positions whose bit is 1; otherwise, the positions whose bit is 0 (at most 3).
REQ-014 Slot filling: selected positions (0..7, local to group) SHALL fill slots 0..3 in ascending order; unused slots SHALL be 8 (the zero input).
REQ-015 When column 0 is consumed with w_valid=1, the new tile SHALL be accepted in the same cycle and its column 7 presented the next cycle with no bubble.
REQ-016 When column 0 is consumed with w_valid=0, the block SHALL return to IDLE with col_valid=0 the next cycle.
REQ-017 In IDLE, col_valid SHALL be 0 and w_data SHALL be ignored unless w_valid=1.
REQ-018 All command outputs SHALL be registered; there SHALL be no combinational path from col_ready to command fields.

Reset
REQ-019 While reset=1, the block SHALL drive: state=IDLE, col_valid=0, w_ready=0, column_idx=0, is_msb=0, load_accum=0, tile_done=0, is_skip_zero all 0, act_sel all 8.
REQ-020 Reset asserted mid-tile SHALL abandon the tile; the first cycle after deassertion SHALL show w_ready=1 and col_valid=0.

Verification
REQ-021 The bench SHALL cover the following scenarios:
- All weights 0x00, w_first=1, col_ready=1: 8 commands 7..0; every group is_skip_zero=1, act_sel all 8; load_accum only on col 7; tile_done only on col 0.
- All weights 0xFF: every column n1=8 -> is_skip_zero=0, act_sel all 8; is_msb only on col 7.
- Group 0 weights (k=0..7) = 1,0,1,0,1,1,0,0: col 0 n1=4 -> skip_zero=1, slots 0,2,4,5; weights 1,1,1,1,1,0,1,0: n1=6 -> skip_zero=0, slots 5,7,8,8.
- col_ready held 0 for 5 cycles on col 4: outputs stable, w_ready=0, then resume col 3.
- Two back-to-back tiles, w_valid=1 continuously: 16 consecutive col_valid cycles, w_ready pulses with col 0, second tile load_accum follows its w_first.
- Reset on col 3: next cycle col_valid=0, w_ready=1; new tile restarts at col 7.
